// File: rtl/minimax_uart_pkg.sv
// Shared constants for the minimax UART transmitter: register offsets,
// STATUS bit positions and the shifter state encoding.
package minimax_uart_pkg;

  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_DIV    = 4'h8;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/minimax_uart_tx_if.sv
// Minimax data-bus slave port: core address/write/read-request in, registered read data out.
interface minimax_uart_tx_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        rreq;
  logic [31:0] rdata;

  modport master (output addr, output wdata, output wmask, output rreq, input rdata);
  modport slave  (input addr, input wdata, input wmask, input rreq, output rdata);
endinterface

// File: rtl/minimax_fifo.sv
// Byte FIFO, DEPTH entries (power of two). Pushes while full and pops while
// empty are ignored; full/empty are evaluated on the count at cycle start.
module minimax_fifo #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    pop_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/minimax_uart_tx.sv
// Memory-mapped 8N1 UART transmitter for the minimax data bus: register block,
// TX byte FIFO and a baud-timed shifter.
//
// state    | meaning
// TX_IDLE  | line high, waiting for a queued byte
// TX_START | start bit (low) for div+1 clocks
// TX_DATA  | 8 data bits, LSB first, div+1 clocks each
// TX_STOP  | stop bit (high); chains straight into TX_START if a byte is queued
module minimax_uart_tx
  import minimax_uart_pkg::*;
#(
  parameter logic [31:0] BASE      = 32'hFFFF_FF00,
  parameter int          DEPTH     = 8,
  parameter logic [15:0] DIV_RESET = 16'd433
) (
  input  logic              clk,
  input  logic              reset,
  minimax_uart_tx_if.slave  bus,
  output logic              txd,
  output logic              irq
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          sel;
  logic          wr_en;
  logic          rd_en;
  logic [3:0]    off;
  logic          push;
  logic          pop;
  logic [7:0]    fifo_pop_data;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          busy;
  logic          unused_bits;

  logic [15:0] div_q;
  logic        ovf_q;
  logic [31:0] rdata_q;
  logic [31:0] rd_value;

  tx_state_t   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] div_frame_q, div_frame_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [2:0]  bit_q, bit_d;
  logic        txd_q, txd_d;
  logic        bit_end;

  assign sel   = (bus.addr[31:4] == BASE[31:4]);
  assign off   = bus.addr[3:0];
  assign wr_en = sel && (bus.wmask != 4'h0);
  assign rd_en = sel && bus.rreq;
  assign push  = wr_en && (off == OFF_TXDATA);

  assign busy        = (state_q != TX_IDLE);
  assign irq         = fifo_empty && (state_q == TX_IDLE);
  assign txd         = txd_q;
  assign bus.rdata   = rdata_q;
  assign unused_bits = ^{bus.wdata[31:16], fifo_count};

  minimax_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (bus.wdata[7:0]),
    .pop       (pop),
    .pop_data  (fifo_pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    rd_value = '0;
    case (off)
      OFF_STATUS: begin
        rd_value[ST_FULL]  = fifo_full;
        rd_value[ST_EMPTY] = fifo_empty;
        rd_value[ST_BUSY]  = busy;
        rd_value[ST_OVF]   = ovf_q;
      end
      OFF_DIV: rd_value[15:0] = div_q;
      default: ;
    endcase
  end

  // Reads see pre-write register values since rd_value comes from current state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_q   <= DIV_RESET;
      ovf_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      rdata_q <= rd_en ? rd_value : '0;
      if (wr_en && (off == OFF_DIV)) div_q <= bus.wdata[15:0];
      if (push && fifo_full)
        ovf_q <= 1'b1;
      else if (wr_en && (off == OFF_STATUS) && bus.wdata[ST_OVF])
        ovf_q <= 1'b0;
    end
  end

  assign bit_end = (cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_frame_d = div_frame_q;
    shreg_d     = shreg_q;
    bit_d       = bit_q;
    pop         = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          shreg_d     = fifo_pop_data;
          cnt_d       = div_q;
          div_frame_d = div_q;
          state_d     = TX_START;
        end
      end
      TX_START: begin
        if (bit_end) begin
          cnt_d   = div_frame_q;
          bit_d   = 3'd0;
          state_d = TX_DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          cnt_d   = div_frame_q;
          shreg_d = shreg_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = TX_STOP;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          // A queued byte starts immediately; divisor is re-sampled per frame.
          if (!fifo_empty) begin
            pop         = 1'b1;
            shreg_d     = fifo_pop_data;
            cnt_d       = div_q;
            div_frame_d = div_q;
            state_d     = TX_START;
          end else begin
            state_d = TX_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = TX_IDLE;
    endcase

    case (state_d)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = shreg_d[0];
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= TX_IDLE;
      cnt_q       <= '0;
      div_frame_q <= '0;
      shreg_q     <= '0;
      bit_q       <= '0;
      txd_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_frame_q <= div_frame_d;
      shreg_q     <= shreg_d;
      bit_q       <= bit_d;
      txd_q       <= txd_d;
    end
  end

endmodule

// File: tb/tb_minimax_uart_tx.sv
// Self-checking bench for minimax_uart_tx: register vector table, hand-built
// frame sequences and randomized bursts checked against an ideal 8N1 waveform.
module tb_minimax_uart_tx;

  localparam logic [31:0] BASE  = 32'hFFFF_FF00;
  localparam logic [31:0] A_TX  = BASE + 32'h0;
  localparam logic [31:0] A_ST  = BASE + 32'h4;
  localparam logic [31:0] A_DIV = BASE + 32'h8;
  localparam logic [31:0] A_RSV = BASE + 32'hC;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic txd;
  logic irq;

  minimax_uart_tx_if bus();

  minimax_uart_tx #(.BASE(BASE), .DEPTH(8), .DIV_RESET(16'd433)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .txd   (txd),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [7:0] data;
    int         div;
  } frame_t;
  frame_t exp_q[$];

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        rreq;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    bus.addr  = 32'h0;
    bus.wdata = 32'h0;
    bus.wmask = 4'h0;
    bus.rreq  = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.wmask = 4'hF;
    bus.rreq  = 1'b0;
    step();
    bus_idle();
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.addr  = a;
    bus.wmask = 4'h0;
    bus.rreq  = 1'b1;
    step();
    d = bus.rdata;
    bus_idle();
  endtask

  // Expected line: each queued frame is start(0), 8 data bits LSB first,
  // stop(1), every bit lasting div+1 clocks, frames abutting with no gap.
  task automatic check_stream(input string name);
    int   t;
    int   errs;
    int   pos;
    int   first_pos;
    logic lvl;
    logic first_act;
    logic first_exp;
    t = 0;
    errs = 0;
    pos = 0;
    first_pos = -1;
    first_act = 1'b0;
    first_exp = 1'b0;
    @(negedge clk);
    while (txd !== 1'b0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (txd !== 1'b0) begin
      check({name, " start bit"}, 32'(txd), 32'h0);
      exp_q.delete();
      return;
    end
    foreach (exp_q[f]) begin
      for (int j = 0; j < 10; j++) begin
        for (int k = 0; k <= exp_q[f].div; k++) begin
          if (j == 0)      lvl = 1'b0;
          else if (j == 9) lvl = 1'b1;
          else             lvl = exp_q[f].data[j-1];
          if (txd !== lvl) begin
            errs++;
            if (first_pos < 0) begin
              first_pos = pos;
              first_act = txd;
              first_exp = lvl;
            end
          end
          pos++;
          @(negedge clk);
        end
      end
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL %s: %0d of %0d line cycles wrong, first at cycle %0d txd got %b want %b",
               name, errs, pos, first_pos, first_act, first_exp);
    end
    check({name, " idle txd"}, 32'(txd), 32'h1);
    check({name, " idle irq"}, 32'(irq), 32'h1);
    exp_q.delete();
  endtask

  logic [31:0] r;
  int          ones;
  int          d;
  int          n;
  logic [7:0]  bq[$];

  initial begin
    bus_idle();
    reset = 1'b0;
    repeat (3) step();
    check("reset txd", 32'(txd), 32'h1);
    check("reset irq", 32'(irq), 32'h1);
    check("reset rdata", bus.rdata, 32'h0);
    reset = 1'b1;

    vt[0]  = '{"status after reset", A_ST,  32'h0,         4'h0, 1'b1, 32'h2};
    vt[1]  = '{"txdata reads 0",     A_TX,  32'h0,         4'h0, 1'b1, 32'h0};
    vt[2]  = '{"div reset",          A_DIV, 32'h0,         4'h0, 1'b1, 32'd433};
    vt[3]  = '{"reserved read",      A_RSV, 32'h0,         4'h0, 1'b1, 32'h0};
    vt[4]  = '{"div write 1 lane",   A_DIV, 32'h1234_5678, 4'h1, 1'b0, 32'h0};
    vt[5]  = '{"div readback",       A_DIV, 32'h0,         4'h0, 1'b1, 32'h5678};
    vt[6]  = '{"reserved write",     A_RSV, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0};
    vt[7]  = '{"reserved after wr",  A_RSV, 32'h0,         4'h0, 1'b1, 32'h0};
    vt[8]  = '{"other base read",    32'hFFFF_FE08, 32'h0, 4'h0, 1'b1, 32'h0};
    vt[9]  = '{"read during write",  A_DIV, 32'h3,         4'hF, 1'b1, 32'h5678};
    vt[10] = '{"no-mask no-write",   A_DIV, 32'h9,         4'h0, 1'b0, 32'h0};
    vt[11] = '{"div new value",      A_DIV, 32'h0,         4'h0, 1'b1, 32'h3};
    vt[12] = '{"selected no rreq",   A_DIV, 32'h0,         4'h0, 1'b0, 32'h0};
    vt[13] = '{"div before low ram", A_DIV, 32'h0,         4'h0, 1'b1, 32'h3};
    for (int i = 0; i < 14; i++) begin
      bus.addr  = vt[i].addr;
      bus.wdata = vt[i].wdata;
      bus.wmask = vt[i].wmask;
      bus.rreq  = vt[i].rreq;
      step();
      check(vt[i].name, bus.rdata, vt[i].exp);
    end
    bus_idle();
    rd(32'h0000_0104, r);
    check("unselected after data", r, 32'h0);

    // Single frame 0xA5 at DIV=3, with a STATUS read mid-frame.
    wr(A_DIV, 32'd3);
    exp_q.push_back('{data: 8'hA5, div: 3});
    fork
      begin
        wr(A_TX, 32'hA5);
        repeat (10) step();
        rd(A_ST, r);
        check("status busy", r, 32'h6);
        check("irq while busy", 32'(irq), 32'h0);
      end
      check_stream("frame a5");
    join

    // Fill the FIFO at DIV=0, overflow on the tenth byte, clear overflow.
    wr(A_DIV, 32'd0);
    for (int i = 0; i < 9; i++) exp_q.push_back('{data: 8'(i), div: 0});
    fork
      begin
        for (int i = 0; i < 9; i++) wr(A_TX, 32'(i));
        rd(A_ST, r);
        check("status full", r, 32'h5);
        wr(A_TX, 32'h09);
        rd(A_ST, r);
        check("status overflow", r, 32'hD);
        wr(A_ST, 32'h8);
        rd(A_ST, r);
        check("status ovf cleared", r, 32'h4);
      end
      check_stream("burst of 9");
    join

    // Back-to-back frames at DIV=1: exactly one stop bit between them.
    wr(A_DIV, 32'd1);
    exp_q.push_back('{data: 8'h55, div: 1});
    exp_q.push_back('{data: 8'hFF, div: 1});
    fork
      begin
        wr(A_TX, 32'h55);
        wr(A_TX, 32'hFF);
      end
      check_stream("back to back");
    join

    // DIV changed mid-frame only takes effect on the following frame.
    wr(A_DIV, 32'd2);
    exp_q.push_back('{data: 8'h3C, div: 2});
    exp_q.push_back('{data: 8'hC3, div: 7});
    fork
      begin
        wr(A_TX, 32'h3C);
        repeat (5) step();
        wr(A_DIV, 32'd7);
        wr(A_TX, 32'hC3);
        rd(A_DIV, r);
        check("div mid-frame read", r, 32'd7);
      end
      check_stream("div change");
    join

    // Randomized bursts: gaps short enough that frames stay contiguous.
    for (int b = 0; b < 4; b++) begin
      d = $urandom_range(0, 3);
      n = $urandom_range(1, 8);
      wr(A_DIV, 32'(d));
      bq.delete();
      for (int k = 0; k < n; k++) begin
        bq.push_back(8'($urandom));
        exp_q.push_back('{data: bq[k], div: d});
      end
      fork
        begin
          foreach (bq[k]) begin
            wr(A_TX, 32'(bq[k]));
            repeat ($urandom_range(0, 2)) step();
          end
        end
        check_stream("random burst");
      join
      rd(A_ST, r);
      check("random status idle", r, 32'h2);
    end

    // Reset during data bit 3 of 0xF0 at DIV=7, with a second byte queued.
    wr(A_DIV, 32'd7);
    wr(A_TX, 32'hF0);
    wr(A_TX, 32'h0F);
    repeat (34) step();
    check("pre-reset bit3", 32'(txd), 32'h0);
    reset = 1'b0;
    step();
    check("mid-frame reset txd", 32'(txd), 32'h1);
    check("mid-frame reset irq", 32'(irq), 32'h1);
    check("mid-frame reset rdata", bus.rdata, 32'h0);
    reset = 1'b1;
    rd(A_ST, r);
    check("status after reset 2", r, 32'h2);
    rd(A_DIV, r);
    check("div after reset 2", r, 32'd433);
    rd(32'h0000_0100, r);
    check("unselected read", r, 32'h0);
    ones = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (txd === 1'b1) ones++;
    end
    check("no frame resumes", 32'(ones), 32'd40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
